// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int LSB_FIRST_C = 1;
    localparam int MSB_FIRST_C = 0;

    // Bits needed to hold a count of 0..w inclusive.
    function automatic int fill_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Direction-parametrised WIDTH-bit shift register with fill counter and a
// word-complete strobe for the bit that finishes a word.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = LSB_FIRST_C,
    localparam int FW       = fill_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] live,
    output logic [WIDTH-1:0] shifted,
    output logic [FW-1:0]    fill,
    output logic             fill_last,
    output logic             word_done
);

    always_comb begin
        shifted = '0;
        if (LSB_FIRST == LSB_FIRST_C) begin
            shifted = {sin, live[WIDTH-1:1]};
        end else begin
            shifted = {live[WIDTH-2:0], sin};
        end
    end

    assign fill_last = (fill == FW'(WIDTH - 1));
    // clear wins over a completing bit, so no word escapes a flush.
    assign word_done = shift_en && fill_last && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live <= '0;
            fill <= '0;
        end else if (clear) begin
            live <= '0;
            fill <= '0;
        end else if (shift_en) begin
            live <= shifted;
            fill <= fill_last ? '0 : fill + FW'(1);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: shift core plus a double-buffered
// holding register presented on a valid/ready output port.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = LSB_FIRST_C,
    localparam int FW       = fill_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FW-1:0]    fill,
    output logic [WIDTH-1:0] live
);

    logic [WIDTH-1:0] shifted;
    logic             fill_last;
    logic             word_done;
    logic             accept;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Once raised, valid holds with stable data until that transfer. Only the
    // word-completing bit is stalled, and only when the holding register is
    // full and not being drained this cycle; sin_ready therefore depends
    // combinationally on out_ready, never on sin_valid.
    assign sin_ready = !(fill_last && out_valid && !out_ready);
    assign accept    = sin_valid && sin_ready;

    sipo_shift_core #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (accept),
        .sin      (sin),
        .live     (live),
        .shifted  (shifted),
        .fill     (fill),
        .fill_last(fill_last),
        .word_done(word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (word_done) begin
            out_data  <= shifted;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
